// File: rtl/dr_phase_ctrl_pkg.sv
// Shared types and constants for the USB2 data-recovery phase controller.
// Also used by the sampler mux for the phase_sel width.
package dr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } dr_state_t;

    localparam int DR_NUM_PHASES = 10;
    localparam int DR_PHASE_W    = 4;

    function automatic logic [DR_PHASE_W-1:0] phase_max(input int n);
        return DR_PHASE_W'(n - 1);
    endfunction

endpackage

// File: rtl/dr_phase_ctrl_if.sv
// Control/status bundle between the sampler front end and dr_phase_ctrl.
// Optional stats signals exist only with DR_PHASE_CTRL_STATS_EN defined.
interface dr_phase_ctrl_if;
    import dr_pkg::*;

    logic                  enable;
    logic                  early;
    logic                  late;
    logic [DR_PHASE_W-1:0] phase_sel;
    logic                  wrap_up;
    logic                  wrap_dn;
    logic                  locked;
    dr_state_t             state;
`ifdef DR_PHASE_CTRL_STATS_EN
    logic [15:0]           step_count;
    logic signed [7:0]     wrap_count;
`endif

    modport master (
        output enable, early, late,
        input  phase_sel, wrap_up, wrap_dn, locked, state
`ifdef DR_PHASE_CTRL_STATS_EN
        , input step_count, wrap_count
`endif
    );

    modport slave (
        input  enable, early, late,
        output phase_sel, wrap_up, wrap_dn, locked, state
`ifdef DR_PHASE_CTRL_STATS_EN
        , output step_count, wrap_count
`endif
    );

endinterface

// File: rtl/dr_phase_ctrl_loop_filter.sv
// First-order loop filter: early/late accumulator, threshold compare and
// modulo phase counter with registered wrap pulses.
module dr_loop_filter
    import dr_pkg::*;
#(
    parameter int NUM_PHASES = DR_NUM_PHASES,
    parameter int ACQ_THRESH = 4,
    parameter int TRK_THRESH = 16
) (
    input  logic                  clock_480,
    input  logic                  reset,
    input  logic                  clr_all,
    input  logic                  reacq,
    input  logic                  acq_mode,
    input  logic                  early,
    input  logic                  late,
    output logic [DR_PHASE_W-1:0] phase_sel,
    output logic                  wrap_up,
    output logic                  wrap_dn,
    output logic                  step_up,
    output logic                  step_dn
);

    localparam int AW = $clog2(TRK_THRESH) + 2;
    localparam logic signed [AW-1:0] ACQ_TH = AW'(ACQ_THRESH);
    localparam logic signed [AW-1:0] TRK_TH = AW'(TRK_THRESH);
    localparam logic signed [AW-1:0] ONE    = AW'(1);
    localparam logic [DR_PHASE_W-1:0] PMAX  = phase_max(NUM_PHASES);

    logic signed [AW-1:0]  acc_q, acc_d, acc_mv, th;
    logic [DR_PHASE_W-1:0] phase_q, phase_d;
    logic                  wu_d, wd_d;

    always_comb begin
        th      = acq_mode ? ACQ_TH : TRK_TH;
        acc_mv  = acc_q;
        if (late && !early)
            acc_mv = acc_q + ONE;
        else if (early && !late)
            acc_mv = acc_q - ONE;
        step_up = !clr_all && (acc_mv == th);
        step_dn = !clr_all && (acc_mv == -th);
        wu_d    = step_up && (phase_q == PMAX);
        wd_d    = step_dn && (phase_q == '0);
        acc_d   = acc_mv;
        phase_d = phase_q;
        if (clr_all) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (reacq) begin
            acc_d = '0;
        end else if (step_up) begin
            acc_d   = '0;
            phase_d = wu_d ? '0 : phase_q + 1'b1;
        end else if (step_dn) begin
            acc_d   = '0;
            phase_d = wd_d ? PMAX : phase_q - 1'b1;
        end
    end

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            phase_q <= '0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            wrap_up <= wu_d;
            wrap_dn <= wd_d;
        end
    end

    assign phase_sel = phase_q;

endmodule

// File: rtl/dr_phase_ctrl.sv
// USB2 480 Mb/s phase-tracking controller: loop FSM, quiet/conflict counters.
// Define DR_PHASE_CTRL_STATS_EN to add step_count/wrap_count outputs.
module dr_phase_ctrl
    import dr_pkg::*;
#(
    parameter int NUM_PHASES   = DR_NUM_PHASES,
    parameter int ACQ_THRESH   = 4,
    parameter int TRK_THRESH   = 16,
    parameter int ACQ_QUIET    = 32,
    parameter int LOCK_QUIET   = 64,
    parameter int CONFLICT_MAX = 8
) (
    input  logic           clock_480,
    input  logic           reset,
    dr_phase_ctrl_if.slave bus
);

    localparam int QW = $clog2(LOCK_QUIET + 1);
    localparam int CW = $clog2(CONFLICT_MAX + 1);

    dr_state_t     state_q, state_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [CW-1:0] conf_q, conf_d;
    logic          both, clr_all, reacq;
    logic          step, step_up, step_dn;
    logic          acq_done, trk_done;

    assign both     = bus.early && bus.late;
    assign clr_all  = !bus.enable || (state_q == IDLE);
    assign reacq    = !clr_all && both
                   && (conf_q == CW'(CONFLICT_MAX - 1));
    assign step     = step_up || step_dn;
    assign acq_done = (state_q == ACQUIRE) && !step
                   && (quiet_q == QW'(ACQ_QUIET - 1));
    assign trk_done = (state_q == TRACK) && !step
                   && (quiet_q == QW'(LOCK_QUIET - 1));

    dr_loop_filter #(
        .NUM_PHASES (NUM_PHASES),
        .ACQ_THRESH (ACQ_THRESH),
        .TRK_THRESH (TRK_THRESH)
    ) u_filter (
        .clock_480 (clock_480),
        .reset     (reset),
        .clr_all   (clr_all),
        .reacq     (reacq),
        .acq_mode  (state_q == ACQUIRE),
        .early     (bus.early),
        .late      (bus.late),
        .phase_sel (bus.phase_sel),
        .wrap_up   (bus.wrap_up),
        .wrap_dn   (bus.wrap_dn),
        .step_up   (step_up),
        .step_dn   (step_dn)
    );

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        conf_d  = '0;
        if (!bus.enable) begin
            state_d = IDLE;
            quiet_d = '0;
        end else if (state_q == IDLE) begin
            state_d = ACQUIRE;
            quiet_d = '0;
        end else if (reacq) begin
            state_d = ACQUIRE;
            quiet_d = '0;
        end else begin
            conf_d = both ? conf_q + 1'b1 : '0;
            unique case (1'b1)
                step: quiet_d = '0;
                acq_done: begin
                    state_d = TRACK;
                    quiet_d = '0;
                end
                trk_done: begin
                    state_d = LOCKED;
                    quiet_d = '0;
                end
                default:
                    quiet_d = (quiet_q == '1) ? quiet_q : quiet_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            quiet_q <= '0;
            conf_q  <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            conf_q  <= conf_d;
        end
    end

    assign bus.state  = state_q;
    assign bus.locked = (state_q == LOCKED);

`ifdef DR_PHASE_CTRL_STATS_EN
    localparam logic [DR_PHASE_W-1:0] PMAX = phase_max(NUM_PHASES);

    logic [15:0]       step_cnt_q;
    logic signed [7:0] wrap_cnt_q;
    logic              wu_evt, wd_evt;

    assign wu_evt = step_up && (bus.phase_sel == PMAX);
    assign wd_evt = step_dn && (bus.phase_sel == '0);

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            step_cnt_q <= '0;
            wrap_cnt_q <= '0;
        end else if (clr_all) begin
            step_cnt_q <= '0;
            wrap_cnt_q <= '0;
        end else begin
            if (step && step_cnt_q != 16'hffff)
                step_cnt_q <= step_cnt_q + 16'd1;
            if (wu_evt && wrap_cnt_q != 8'sh7f)
                wrap_cnt_q <= wrap_cnt_q + 8'sd1;
            else if (wd_evt && wrap_cnt_q != -8'sh80)
                wrap_cnt_q <= wrap_cnt_q - 8'sd1;
        end
    end

    assign bus.step_count = step_cnt_q;
    assign bus.wrap_count = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_dr_phase_ctrl.sv
// Scoreboard bench for dr_phase_ctrl: directed scenarios plus random
// early/late traffic checked against a behavioural model.
module tb_dr_phase_ctrl;
    import dr_pkg::*;

    logic clock_480 = 1'b0;
    logic reset     = 1'b1;
    always #5 clock_480 = ~clock_480;

    dr_phase_ctrl_if bus ();

    dr_phase_ctrl dut (
        .clock_480 (clock_480),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        int ph;
        int wu;
        int wd;
        int lk;
        int st;
        int sc;
        int wc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int m_st, m_acc, m_ph, m_q, m_cf, m_sc, m_wc, m_wu, m_wd;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Spec-level model of one clock edge with inputs (en, e, l).
    function automatic void model_step(input bit en, input bit e,
                                       input bit l);
        int th, a;
        bit stepped;
        m_wu = 0;
        m_wd = 0;
        if (!en) begin
            m_st = 0; m_acc = 0; m_ph = 0; m_q = 0; m_cf = 0;
            m_sc = 0; m_wc = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_q = 0; m_cf = 0; m_sc = 0; m_wc = 0;
        end else if (e && l && m_cf == 7) begin
            m_st = 1; m_acc = 0; m_q = 0; m_cf = 0;
        end else begin
            m_cf    = (e && l) ? m_cf + 1 : 0;
            th      = (m_st == 1) ? 4 : 16;
            a       = m_acc + ((l && !e) ? 1 : 0) - ((e && !l) ? 1 : 0);
            stepped = 0;
            if (a == th) begin
                m_ph = (m_ph + 1) % 10;
                m_wu = (m_ph == 0);
                m_acc = 0; stepped = 1;
            end else if (a == -th) begin
                m_wd = (m_ph == 0);
                m_ph = (m_ph + 9) % 10;
                m_acc = 0; stepped = 1;
            end else begin
                m_acc = a;
            end
            if (stepped) begin
                m_q = 0;
                if (m_sc < 65535) m_sc++;
                if (m_wu && m_wc < 127) m_wc++;
                if (m_wd && m_wc > -128) m_wc--;
            end else if (m_st == 1 && m_q == 31) begin
                m_st = 2; m_q = 0;
            end else if (m_st == 2 && m_q == 63) begin
                m_st = 3; m_q = 0;
            end else if (m_q < 1000) begin
                m_q++;
            end
        end
    endfunction

    task automatic drive(input bit en, input bit e, input bit l);
        exp_t x;
        @(posedge clock_480);
        #2;
        bus.enable = en;
        bus.early  = e;
        bus.late   = l;
        model_step(en, e, l);
        x.ph = m_ph; x.wu = m_wu; x.wd = m_wd;
        x.lk = (m_st == 3) ? 1 : 0;
        x.st = m_st; x.sc = m_sc; x.wc = m_wc;
        sbq.push_back(x);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clock_480);
            #1;
            cyc++;
            if (sbq.size() > 0) begin
                exp_t x;
                x = sbq.pop_front();
                chk("phase_sel", int'(bus.phase_sel), x.ph);
                chk("wrap_up", int'(bus.wrap_up), x.wu);
                chk("wrap_dn", int'(bus.wrap_dn), x.wd);
                chk("locked", int'(bus.locked), x.lk);
                chk("state", int'(bus.state), x.st);
`ifdef DR_PHASE_CTRL_STATS_EN
                chk("step_count", int'(bus.step_count), x.sc);
                chk("wrap_count", int'(bus.wrap_count), x.wc);
`endif
            end
        end
    end

    initial begin : stim
        int mode, len;
        bit e, l, en;
        bus.enable = 1'b0;
        bus.early  = 1'b0;
        bus.late   = 1'b0;
        m_st = 0; m_acc = 0; m_ph = 0; m_q = 0; m_cf = 0;
        m_sc = 0; m_wc = 0; m_wu = 0; m_wd = 0;
        repeat (2) @(posedge clock_480);
        #1;
        chk("rst_phase", int'(bus.phase_sel), 0);
        chk("rst_wrap_up", int'(bus.wrap_up), 0);
        chk("rst_wrap_dn", int'(bus.wrap_dn), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_state", int'(bus.state), 0);
        @(posedge clock_480);
        #2;
        reset = 1'b0;

        // acquire, track, lock with a quiet line
        repeat (1 + 32 + 64) drive(1, 0, 0);
        // conflict burst forces re-acquisition
        repeat (8) drive(1, 1, 1);
        // fast stepping in ACQUIRE through a full wrap
        repeat (40) drive(1, 0, 1);
        repeat (96) drive(1, 0, 0);
        // slow stepping in LOCKED, 0 -> 9 wrap down
        repeat (20) drive(1, 1, 0);
        // disable in TRACK with acc at +15
        drive(0, 0, 0);
        repeat (33) drive(1, 0, 0);
        repeat (15) drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 0);

        for (int s = 0; s < 60; s++) begin
            mode = $urandom_range(0, 4);
            len  = $urandom_range(5, 120);
            for (int c = 0; c < len; c++) begin
                en = ($urandom_range(0, 299) != 0);
                e  = 1'b0;
                l  = 1'b0;
                case (mode)
                    1: begin
                        l = 1'b1;
                        e = ($urandom_range(0, 7) == 0);
                    end
                    2: begin
                        e = 1'b1;
                        l = ($urandom_range(0, 7) == 0);
                    end
                    3: begin
                        e = $urandom_range(0, 1) != 0;
                        l = $urandom_range(0, 1) != 0;
                    end
                    4: begin
                        e = ($urandom_range(0, 7) != 0);
                        l = e;
                    end
                    default: ;
                endcase
                drive(en, e, l);
            end
        end

        // async reset while a wrap_up pulse is high
        drive(0, 0, 0);
        drive(1, 0, 0);
        repeat (40) drive(1, 0, 1);
        @(posedge clock_480);
        #3;
        chk("pre_rst_wrap_up", int'(bus.wrap_up), 1);
        reset = 1'b1;
        #1;
        chk("arst_wrap_up", int'(bus.wrap_up), 0);
        chk("arst_state", int'(bus.state), 0);
        chk("arst_phase", int'(bus.phase_sel), 0);
        chk("arst_locked", int'(bus.locked), 0);
        bus.enable = 1'b0;
        bus.late   = 1'b0;
        repeat (2) @(posedge clock_480);
        @(negedge clock_480);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock_480);
            #1;
            chk("post_rst_wrap_up", int'(bus.wrap_up), 0);
            chk("post_rst_wrap_dn", int'(bus.wrap_dn), 0);
            chk("post_rst_state", int'(bus.state), 0);
        end
        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
